fpdiv_issue: RTL and testbench

FPDIV_ISSUE -- requirements
Module: fpdiv_issue

---
 rtl/fpdiv_pkg.sv | 24 ++
 rtl/fp_classify.sv | 28 ++
 rtl/fpdiv_issue.sv | 165 ++++++++++++++++
 tb/tb_fpdiv_issue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpdiv_pkg : shared state encoding, exception codes and IEEE consts    |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package fpdiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    WAIT     = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [1:0]  EXC_NONE = 2'b00;
  localparam logic [1:0]  EXC_DZ   = 2'b01;
  localparam logic [1:0]  EXC_INV  = 2'b10;
  localparam logic [1:0]  EXC_OVF  = 2'b11;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_classify : combinational decode of one single-precision operand    |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module fp_classify
  import fpdiv_pkg::*;
(
  input  logic [31:0] i_value,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_sub
);

  logic [7:0] w_exp;
  logic       w_frac_nz;

  assign w_exp     = i_value[30:23];
  assign w_frac_nz = |i_value[22:0];

  assign is_zero = (w_exp == 8'd0)    && !w_frac_nz;
  assign is_sub  = (w_exp == 8'd0)    &&  w_frac_nz;
  assign is_inf  = (w_exp == EXP_MAX) && !w_frac_nz;
  assign is_nan  = (w_exp == EXP_MAX) &&  w_frac_nz;

endmodule
`default_nettype wire

// File: rtl/fpdiv_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpdiv_issue : operand issue, special-case handling and result hold    |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module fpdiv_issue
  import fpdiv_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] InputA,
  input  logic [31:0] InputB,
  output logic [31:0] DIV_A,
  output logic [31:0] DIV_B,
  input  logic [31:0] DIV_RESULT,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] AbyB,
  output logic [1:0]  EXCEPTION,
  output logic        DONE
);

  localparam logic [4:0] c_cnt_init = 5'(LATENCY - 1);

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_div_a, r_div_b, r_aby_b;
  logic [1:0]  r_exc;
  logic        r_out_valid;

  logic        w_a_is_zero, w_a_is_inf, w_a_is_nan, w_a_is_sub;
  logic        w_b_is_zero, w_b_is_inf, w_b_is_nan, w_b_is_sub;
  logic        w_a_zero, w_b_zero, w_sign;
  logic        w_special;
  logic [31:0] w_spec_res, w_cap_res;
  logic [1:0]  w_spec_exc, w_cap_exc;
  logic        w_unused_sign;

  fp_classify u_cls_a (
    .i_value (r_div_a),
    .is_zero (w_a_is_zero),
    .is_inf  (w_a_is_inf),
    .is_nan  (w_a_is_nan),
    .is_sub  (w_a_is_sub)
  );

  fp_classify u_cls_b (
    .i_value (r_div_b),
    .is_zero (w_b_is_zero),
    .is_inf  (w_b_is_inf),
    .is_nan  (w_b_is_nan),
    .is_sub  (w_b_is_sub)
  );

  // Subnormals are flushed to zero before any special-case decision.
  assign w_a_zero      = w_a_is_zero | w_a_is_sub;
  assign w_b_zero      = w_b_is_zero | w_b_is_sub;
  assign w_sign        = r_div_a[31] ^ r_div_b[31];
  assign w_unused_sign = DIV_RESULT[31];

  always_comb begin
    w_special  = 1'b1;
    w_spec_res = '0;
    w_spec_exc = EXC_NONE;
    if (w_a_is_nan || w_b_is_nan) begin
      w_spec_res = QNAN;
      w_spec_exc = EXC_INV;
    end else if ((w_a_zero && w_b_zero) || (w_a_is_inf && w_b_is_inf)) begin
      w_spec_res = QNAN;
      w_spec_exc = EXC_INV;
    end else if (w_b_zero && !w_a_is_inf) begin
      w_spec_res = {w_sign, EXP_MAX, 23'd0};
      w_spec_exc = EXC_DZ;
    end else if (w_a_is_inf) begin
      w_spec_res = {w_sign, EXP_MAX, 23'd0};
      w_spec_exc = EXC_OVF;
    end else if (w_b_is_inf || w_a_zero) begin
      w_spec_res = {w_sign, 31'd0};
      w_spec_exc = EXC_NONE;
    end else begin
      w_special  = 1'b0;
    end
  end

  always_comb begin
    w_cap_res = {w_sign, DIV_RESULT[30:0]};
    w_cap_exc = EXC_NONE;
    if (DIV_RESULT[30:23] == EXP_MAX) begin
      w_cap_res = {w_sign, EXP_MAX, 23'd0};
      w_cap_exc = EXC_OVF;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (IN_VALID) w_next = CLASSIFY;
      CLASSIFY: w_next = w_special ? RESP : WAIT;
      WAIT:     if (r_cnt == 5'd0) w_next = RESP;
      RESP:     if (OUT_READY) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_cnt       <= 5'd0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_aby_b     <= '0;
      r_exc       <= EXC_NONE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            r_div_a <= InputA;
            r_div_b <= InputB;
          end
        end
        CLASSIFY: begin
          if (w_special) begin
            r_aby_b     <= w_spec_res;
            r_exc       <= w_spec_exc;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= c_cnt_init;
          end
        end
        WAIT: begin
          if (r_cnt == 5'd0) begin
            r_aby_b     <= w_cap_res;
            r_exc       <= w_cap_exc;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        RESP: begin
          if (OUT_READY) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign IN_READY  = (r_state == IDLE);
  assign DONE      = (r_state == RESP) && OUT_READY;
  assign DIV_A     = r_div_a;
  assign DIV_B     = r_div_b;
  assign AbyB      = r_aby_b;
  assign EXCEPTION = r_exc;
  assign OUT_VALID = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fpdiv_issue.sv
`default_nettype none
// Self-checking bench for fpdiv_issue: directed special cases plus randomized
// operands against a category-based reference model and a stand-in divider.
module tb_fpdiv_issue;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [31:0] div_a, div_b, div_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] aby_b;
  logic [1:0]  exception;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fpdiv_issue #(.LATENCY(LAT)) dut (
    .CLOCK      (clk),
    .RESET      (rst_n),
    .IN_VALID   (in_valid),
    .IN_READY   (in_ready),
    .InputA     (in_a),
    .InputB     (in_b),
    .DIV_A      (div_a),
    .DIV_B      (div_b),
    .DIV_RESULT (div_result),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .AbyB       (aby_b),
    .EXCEPTION  (exception),
    .DONE       (done)
  );

  // Stand-in divider: two known quotients, otherwise an arbitrary mix of the operands.
  function automatic logic [31:0] standin(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h41C00000 && b == 32'h40C00000) return 32'h40800000;
    if (a == 32'h7F000000 && b == 32'h3F000000) return 32'h7F800000;
    return a ^ {b[7:0], b[31:8]} ^ 32'h1357_9BDF;
  endfunction

  assign div_result = standin(div_a, div_b);

  // 0 = zero (incl. subnormal), 1 = finite nonzero, 2 = infinity, 3 = NaN
  function automatic int category(input logic [31:0] v);
    if (v[30:23] == 8'h00) return 0;
    if (v[30:23] != 8'hFF) return 1;
    return (v[22:0] == 0) ? 2 : 3;
  endfunction

  function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b);
    int ca = category(a);
    int cb = category(b);
    logic s = a[31] ^ b[31];
    logic [31:0] q;
    if (ca == 3 || cb == 3)                        return {32'h7FC00000, 2'b10};
    if ((ca == 0 && cb == 0) || (ca == 2 && cb == 2)) return {32'h7FC00000, 2'b10};
    if (cb == 0 && ca == 1)                        return {s, 8'hFF, 23'd0, 2'b01};
    if (ca == 2)                                   return {s, 8'hFF, 23'd0, 2'b11};
    if (cb == 2 || ca == 0)                        return {s, 31'd0, 2'b00};
    q = standin(a, b);
    if (q[30:23] == 8'hFF)                         return {s, 8'hFF, 23'd0, 2'b11};
    return {s, q[30:0], 2'b00};
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
    return (category(a) == 1 && category(b) == 1) ? 2 + LAT : 2;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:0] = 31'd0;
      1: v[30:23] = 8'd0;
      2: v[30:0] = {8'hFF, 23'd0};
      3: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      default: if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) v[30:23] = 8'h80;
    endcase
    return v;
  endfunction

  // Issues one pair, waits for the result (bounded), applies 'hold' cycles of
  // backpressure with IN_VALID noise, then completes the handshake.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                       output int lat, output logic [31:0] res, output logic [1:0] exc,
                       output bit stable, output int dones, output bit post_ok);
    lat = 0; dones = 0; stable = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    do begin
      @(negedge clk);
      lat++;
      dones += int'(done);
      in_valid = 1'($urandom_range(0, 1)); in_a = $urandom; in_b = $urandom;
    end while (!out_valid && lat < 200);
    res = aby_b; exc = exception;
    repeat (hold) begin
      @(negedge clk);
      dones += int'(done);
      if (!out_valid || aby_b !== res || exception !== exc || in_ready) stable = 1'b0;
      in_valid = 1'($urandom_range(0, 1)); in_a = $urandom; in_b = $urandom;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1 dones += int'(done);
    @(negedge clk);
    dones += int'(done);
    post_ok = !out_valid && in_ready;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (aby_b !== 32'd0)   $display("FAIL rst_abyb got %h want 0", aby_b); else n_pass++;
    n_checks++; if (exception !== 2'b00) $display("FAIL rst_exc got %b want 00", exception); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_ovalid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (done !== 1'b0)      $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_checks++; if (div_a !== 32'd0 || div_b !== 32'd0) $display("FAIL rst_div got %h/%h want 0/0", div_a, div_b); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1)  $display("FAIL rst_inready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic run_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] want_res, input logic [1:0] want_exc, input int want_lat);
    int lat, dones; logic [31:0] res; logic [1:0] exc; bit stable, post_ok;
    do_op(a, b, 0, lat, res, exc, stable, dones, post_ok);
    n_checks++; if (lat !== want_lat) $display("FAIL %s_lat got %0d want %0d", name, lat, want_lat); else n_pass++;
    n_checks++; if (res !== want_res) $display("FAIL %s_res got %h want %h", name, res, want_res); else n_pass++;
    n_checks++; if (exc !== want_exc) $display("FAIL %s_exc got %b want %b", name, exc, want_exc); else n_pass++;
    n_checks++; if (dones !== 1 || !post_ok) $display("FAIL %s_done got %0d/%0b want 1/1", name, dones, post_ok); else n_pass++;
  endtask

  task automatic test_normal();
    run_directed("norm", 32'h41C00000, 32'h40C00000, 32'h40800000, 2'b00, 2 + LAT);
    n_checks++; if (div_a !== 32'h41C00000 || div_b !== 32'h40C00000)
      $display("FAIL norm_hold got %h/%h want 41c00000/40c00000", div_a, div_b); else n_pass++;
  endtask

  task automatic test_special();
    run_directed("dz_pos",  32'h40000000, 32'h00000000, 32'h7F800000, 2'b01, 2);
    run_directed("dz_neg",  32'hC0000000, 32'h00000000, 32'hFF800000, 2'b01, 2);
    run_directed("zz",      32'h00000000, 32'h00000000, 32'h7FC00000, 2'b10, 2);
    run_directed("ii",      32'h7F800000, 32'h7F800000, 32'h7FC00000, 2'b10, 2);
    run_directed("nan",     32'h7FF80000, 32'h40000000, 32'h7FC00000, 2'b10, 2);
    run_directed("fin_inf", 32'h40000000, 32'h7F800000, 32'h00000000, 2'b00, 2);
    run_directed("sub_fin", 32'h80000001, 32'h40000000, 32'h80000000, 2'b00, 2);
    run_directed("inf_fin", 32'hFF800000, 32'h40000000, 32'hFF800000, 2'b11, 2);
    run_directed("ovf",     32'h7F000000, 32'h3F000000, 32'h7F800000, 2'b11, 2 + LAT);
  endtask

  task automatic test_backpressure();
    int lat, dones; logic [31:0] res; logic [1:0] exc; bit stable, post_ok;
    do_op(32'h41C00000, 32'h40C00000, 3, lat, res, exc, stable, dones, post_ok);
    n_checks++; if (!stable) $display("FAIL bp_stable got 0 want 1"); else n_pass++;
    n_checks++; if (dones !== 1) $display("FAIL bp_done got %0d want 1", dones); else n_pass++;
    n_checks++; if (res !== 32'h40800000 || !post_ok) $display("FAIL bp_res got %h/%0b want 40800000/1", res, post_ok); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h41C00000; in_b = 32'h40C00000;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (div_a !== 32'd0 || div_b !== 32'd0 || aby_b !== 32'd0 || exception !== 2'b00 || out_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL midrst_vals got %h %h %h %b %b %b want zeros", div_a, div_b, aby_b, exception, out_valid, done); else n_pass++;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_inready got %b want 1", in_ready); else n_pass++;
    repeat (LAT + 6) begin
      @(negedge clk);
      if (out_valid || done) seen++;
    end
    out_ready = 1'b0;
    n_checks++; if (seen !== 0) $display("FAIL midrst_ghost got %0d want 0", seen); else n_pass++;
  endtask

  task automatic test_random();
    int lat, dones; logic [31:0] res, a, b; logic [1:0] exc; bit stable, post_ok;
    logic [33:0] want;
    for (int i = 0; i < 40; i++) begin
      a = rand_op(); b = rand_op();
      want = ref_model(a, b);
      do_op(a, b, $urandom_range(0, 2), lat, res, exc, stable, dones, post_ok);
      n_checks++; if ({res, exc} !== want) $display("FAIL rnd%0d_res %h/%h got %h,%b want %h,%b", i, a, b, res, exc, want[33:2], want[1:0]); else n_pass++;
      n_checks++; if (lat !== exp_latency(a, b)) $display("FAIL rnd%0d_lat got %0d want %0d", i, lat, exp_latency(a, b)); else n_pass++;
      n_checks++; if (!stable || dones !== 1 || !post_ok) $display("FAIL rnd%0d_hs got %0b/%0d/%0b want 1/1/1", i, stable, dones, post_ok); else n_pass++;
      n_checks++; if (div_a !== a || div_b !== b) $display("FAIL rnd%0d_hold got %h/%h want %h/%h", i, div_a, div_b, a, b); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
